// File: rtl/aes_lite_req_arbiter_pkg.sv
// Shared types and helpers for the AES-lite request arbiter: FSM state encoding,
// default data/key widths and the requester-id width function.
package aes_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned AES_DW_DEFAULT = 8;
    localparam int unsigned AES_KW_DEFAULT = 8;

    // A single requester still needs a one-bit id field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_lite_req_arbiter_if.sv
// Requester, core and response channels of the AES-lite arbiter bundled in one interface.
// slave = arbiter view, master = environment (requesters, core, response sink).
interface aes_lite_req_arbiter_if
    import aes_lite_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = AES_DW_DEFAULT,
    parameter int unsigned KW   = AES_KW_DEFAULT
);
    localparam int unsigned IDW = id_width(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*KW-1:0] req_key;

    logic               core_start;
    logic [DW-1:0]      core_data;
    logic [KW-1:0]      core_key;
    logic               core_done;
    logic [DW-1:0]      core_result;
    logic               core_abort;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_data, req_key, core_done, core_result, rsp_ready,
        output req_ready, core_start, core_data, core_key, core_abort,
               rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_data, req_key, core_done, core_result, rsp_ready,
        input  req_ready, core_start, core_data, core_key, core_abort,
               rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/aes_lite_req_arbiter_rr_arb.sv
// Combinational round-robin picker: one-hot grant to the first valid request at or
// after the pointer, wrapping from NREQ-1 back to 0.
module aes_lite_rr_arb
    import aes_lite_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            any_o
);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned    idx_int;
        logic [IDW-1:0] idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx_int  = 0;
        idx      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_int = 32'(ptr_i) + i;
            if (idx_int >= NREQ) begin
                idx_int = idx_int - NREQ;
            end
            idx = IDW'(idx_int);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/aes_lite_req_arbiter.sv
// Round-robin arbiter sharing one AES-lite core between NREQ requesters.
// Optional core watchdog enabled with `define AES_ARB_TIMEOUT_EN.
module aes_lite_req_arbiter
    import aes_lite_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = AES_DW_DEFAULT,
    parameter int unsigned KW      = AES_KW_DEFAULT,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_lite_req_arbiter_if.slave bus
);

    localparam int unsigned IDW = id_width(NREQ);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [DW-1:0]  data_q, data_d;
    logic [KW-1:0]  key_q, key_d;
    logic [DW-1:0]  result_q, result_d;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_id;
    logic            any_req;
    logic [DW-1:0]   sel_data;
    logic [KW-1:0]   sel_key;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
`endif

    aes_lite_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req_i    (bus.req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt_onehot),
        .gnt_id_o (gnt_id),
        .any_o    (any_req)
    );

    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_onehot[i]) begin
                sel_data = sel_data | bus.req_data[i*DW +: DW];
                sel_key  = sel_key  | bus.req_key[i*KW +: KW];
            end
        end
    end

    // core_done only matters in WAIT; rsp_ready only in RESP.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        data_d        = data_q;
        key_d         = key_q;
        result_d      = result_q;
        bus.req_ready = '0;
`ifdef AES_ARB_TIMEOUT_EN
        wdog_d         = wdog_q;
        err_d          = err_q;
        bus.core_abort = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    bus.req_ready = gnt_onehot;
                    gnt_d         = gnt_id;
                    data_d        = sel_data;
                    key_d         = sel_key;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef AES_ARB_TIMEOUT_EN
                wdog_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef AES_ARB_TIMEOUT_EN
                wdog_d = wdog_q + CW'(1);
`endif
                if (bus.core_done) begin
                    result_d = bus.core_result;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ST_RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                // A done arriving on the expiry cycle takes priority over the abort.
                else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    bus.core_abort = 1'b1;
                    result_d       = '0;
                    err_d          = 1'b1;
                    state_d        = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            data_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            data_q   <= data_d;
            key_q    <= key_d;
            result_q <= result_d;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err    = 1'b0;
    assign bus.core_abort = 1'b0;
`endif

    assign bus.core_start = (state_q == ST_ISSUE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.core_data  = data_q;
    assign bus.core_key   = key_q;
    assign bus.rsp_id     = gnt_q;
    assign bus.rsp_data   = result_q;

endmodule

// File: tb/tb_aes_lite_req_arbiter.sv
// Directed bench for aes_lite_req_arbiter; the bench plays requesters, core and response sink.
// Watchdog cases run when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_lite_req_arbiter;
    import aes_lite_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned KW      = 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errCount   = 0;
    int   checkCount = 0;

    aes_lite_req_arbiter_if #(.NREQ(NREQ), .DW(DW), .KW(KW)) bus ();

    aes_lite_req_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .KW      (KW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rspReady,
                                 input logic coreDone, input logic [DW-1:0] coreResult);
        bus.req_valid   = valid;
        bus.rsp_ready   = rspReady;
        bus.core_done   = coreDone;
        bus.core_result = coreResult;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, start, waitCycles idle WAIT cycles, done,
    // holdCycles of response backpressure, then the handshake.
    task automatic runTxn(input logic [NREQ-1:0] valid, input int expGnt,
                          input logic [DW-1:0] expData, input logic [KW-1:0] expKey,
                          input logic [DW-1:0] result, input int waitCycles,
                          input int holdCycles);
        applyStimulus(valid, 1'b0, 1'b0, 8'h00);
        checkOutput("accept req_ready", 32'(bus.req_ready), 32'(1) << expGnt);
        tick();
        applyStimulus(valid, 1'b0, 1'b0, 8'h00);
        checkOutput("issue core_start", 32'(bus.core_start), 32'd1);
        checkOutput("issue core_data", 32'(bus.core_data), 32'(expData));
        checkOutput("issue core_key", 32'(bus.core_key), 32'(expKey));
        checkOutput("issue req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        for (int w = 0; w < waitCycles; w++) begin
            applyStimulus(valid, 1'b0, 1'b0, 8'h00);
            checkOutput("wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        applyStimulus(valid, 1'b0, 1'b1, result);
        checkOutput("done core_start", 32'(bus.core_start), 32'd0);
        tick();
        for (int h = 0; h < holdCycles; h++) begin
            applyStimulus(valid, 1'b0, 1'b0, 8'h00);
            checkOutput("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold rsp_id", 32'(bus.rsp_id), 32'(expGnt));
            checkOutput("hold rsp_data", 32'(bus.rsp_data), 32'(result));
            checkOutput("hold req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        applyStimulus(valid, 1'b0, 1'b0, 8'h00);
        checkOutput("resp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("resp rsp_id", 32'(bus.rsp_id), 32'(expGnt));
        checkOutput("resp rsp_data", 32'(bus.rsp_data), 32'(result));
        checkOutput("resp rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("resp core_abort", 32'(bus.core_abort), 32'd0);
        applyStimulus(valid, 1'b1, 1'b0, 8'h00);
        tick();
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_data    = {8'h5A, 8'h00, 8'hFF, 8'hAA};
        bus.req_key     = {8'h44, 8'h33, 8'h22, 8'h55};
        bus.rsp_ready   = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset core_start", 32'(bus.core_start), 32'd0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset core_data", 32'(bus.core_data), 32'd0);
        checkOutput("reset rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("reset core_abort", 32'(bus.core_abort), 32'd0);
        checkOutput("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;

        // Test 1: single request, done 5 cycles after start
        applyStimulus(4'b0001, 1'b0, 1'b0, 8'h00);
        checkOutput("t1 c0 req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t1 c1 core_start", 32'(bus.core_start), 32'd1);
        checkOutput("t1 c1 core_data", 32'(bus.core_data), 32'hAA);
        checkOutput("t1 c1 core_key", 32'(bus.core_key), 32'h55);
        for (int c = 2; c <= 5; c++) begin
            tick();
            checkOutput("t1 wait core_start", 32'(bus.core_start), 32'd0);
            checkOutput("t1 wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'h3C);
        checkOutput("t1 c6 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t1 c7 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t1 c7 rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("t1 c7 rsp_data", 32'(bus.rsp_data), 32'h3C);
        checkOutput("t1 c7 rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("t1 c7 core_data", 32'(bus.core_data), 32'hAA);
        applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t1 c8 rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Test 2: reset pointer to 0, all four valid continuously
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.req_data = {8'h5A, 8'h00, 8'hFF, 8'h12};
        bus.req_key  = {8'h44, 8'h33, 8'h22, 8'h11};
        runTxn(4'hF, 0, 8'h12, 8'h11, 8'hA1, 0, 0);
        runTxn(4'hF, 1, 8'hFF, 8'h22, 8'hB2, 0, 0);
        runTxn(4'hF, 2, 8'h00, 8'h33, 8'hC3, 0, 0);
        runTxn(4'hF, 3, 8'h5A, 8'h44, 8'hD4, 0, 0);
        runTxn(4'hF, 0, 8'h12, 8'h11, 8'hE5, 0, 0);

        // Test 3: backpressure for 10 cycles (pointer now 1)
        runTxn(4'hF, 1, 8'hFF, 8'h22, 8'h77, 1, 10);

        // Test 4: spurious core_done in IDLE and ISSUE (pointer now 2)
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'h99);
        checkOutput("t4 idle rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t4 idle core_start", 32'(bus.core_start), 32'd0);
        tick();
        checkOutput("t4 idle2 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t4 idle2 core_start", 32'(bus.core_start), 32'd0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00);
        checkOutput("t4 req_ready", 32'(bus.req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'h99);
        checkOutput("t4 issue core_start", 32'(bus.core_start), 32'd1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t4 wait1 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("t4 wait2 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'h5E);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t4 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t4 rsp_id", 32'(bus.rsp_id), 32'd2);
        checkOutput("t4 rsp_data", 32'(bus.rsp_data), 32'h5E);
        applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
        tick();

        // Test 5: reset in WAIT drops the transaction and the pointer (pointer now 3)
        applyStimulus(4'b1000, 1'b0, 1'b0, 8'h00);
        checkOutput("t5 req_ready", 32'(bus.req_ready), 32'h8);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("t5 rst core_start", 32'(bus.core_start), 32'd0);
        checkOutput("t5 rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("t5 rst core_data", 32'(bus.core_data), 32'd0);
        checkOutput("t5 rst core_key", 32'(bus.core_key), 32'd0);
        checkOutput("t5 rst rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("t5 rst rsp_data", 32'(bus.rsp_data), 32'd0);
        rst = 1'b0;
        bus.req_data = {8'h5A, 8'h6B, 8'hFF, 8'h12};
        runTxn(4'b1100, 2, 8'h6B, 8'h33, 8'h42, 2, 0);

`ifdef AES_ARB_TIMEOUT_EN
        // Test 6a: core never done (pointer now 3, request 1 wraps to grant 1)
        applyStimulus(4'b0010, 1'b0, 1'b0, 8'h00);
        checkOutput("t6 req_ready", 32'(bus.req_ready), 32'h2);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        tick();
        for (int w = 1; w < int'(TIMEOUT); w++) begin
            checkOutput("t6 early core_abort", 32'(bus.core_abort), 32'd0);
            tick();
        end
        checkOutput("t6 expiry core_abort", 32'(bus.core_abort), 32'd1);
        checkOutput("t6 expiry rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("t6 resp core_abort", 32'(bus.core_abort), 32'd0);
        checkOutput("t6 resp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t6 resp rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("t6 resp rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("t6 resp rsp_id", 32'(bus.rsp_id), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
        tick();

        // Test 6b: done on the expiry cycle wins (pointer now 2)
        applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00);
        checkOutput("t6b req_ready", 32'(bus.req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        tick();
        repeat (TIMEOUT - 1) tick();
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'hC7);
        checkOutput("t6b expiry core_abort", 32'(bus.core_abort), 32'd0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
        checkOutput("t6b rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t6b rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("t6b rsp_data", 32'(bus.rsp_data), 32'hC7);
        applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
